// File: rtl/link_pkg.sv
// Purpose: shared symbol constants and scheduler state encoding for the link transmit path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package link_pkg;

  // 8b/10b control characters driven with K=1
  localparam logic [7:0] K28_5 = 8'hBC;  // comma: alignment and idle fill
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
  localparam logic [7:0] K28_0 = 8'h1C;  // in-frame filler when the source stalls

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_ALIGN = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SOF   = 3'd3,
    ST_DATA  = 3'd4,
    ST_EOF   = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Purpose: two-way round-robin pick between byte-stream requesters at a frame boundary.
// Latency: combinational.
// Backpressure: none; gnt_valid is low when disabled or nobody requests.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       arb_en,
  output logic       gnt_valid,
  output logic       gnt
);

  // A lone requester wins outright; a tie goes to the channel not served last
  always_comb begin
    gnt_valid = arb_en && (req != 2'b00);
    gnt       = 1'b0;
    if (req == 2'b11) begin
      gnt = ~last_grant;
    end else begin
      gnt = req[1];
    end
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// Purpose: sequences the 8b/10b encoder: comma alignment, then SOF/data/EOF frames from two channels with comma idle fill.
// Latency: each encoder symbol is registered and shows the choice made in the previous state cycle; FB follows the SOF state by one cycle.
// Backpressure: chX_ready is high through DATA for the granted channel; a stalled source yields K28.0 fillers, frame is cut at MAX_LEN.
module link_tx_scheduler
  import link_pkg::*;
#(
  parameter int ALIGN_COUNT = 4,
  parameter int MAX_LEN     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link_en,
  input  logic       ch0_valid,
  input  logic [7:0] ch0_data,
  input  logic       ch0_last,
  output logic       ch0_ready,
  input  logic       ch1_valid,
  input  logic [7:0] ch1_data,
  input  logic       ch1_last,
  output logic       ch1_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       enc_enb,
  output logic       aligned,
  output logic       grant,
  output logic       trunc
);

  localparam int AW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
  localparam int BW = $clog2(MAX_LEN + 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_COUNT - 1);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(MAX_LEN - 1);

  state_t        state;
  logic [AW-1:0] align_cnt;
  logic [BW-1:0] byte_cnt;
  logic          last_grant;
  logic          trunc_pend;

  logic          sel_valid;
  logic [7:0]    sel_data;
  logic          sel_last;
  logic          xfer;
  logic          cnt_hit;
  logic          end_frame;
  logic          gnt_valid;
  logic          gnt;

  // Ready depends only on registered state so sources never see a valid->ready loop
  assign ch0_ready = (state == ST_DATA) && (grant == 1'b0);
  assign ch1_ready = (state == ST_DATA) && (grant == 1'b1);

  assign sel_valid = grant ? ch1_valid : ch0_valid;
  assign sel_data  = grant ? ch1_data  : ch0_data;
  assign sel_last  = grant ? ch1_last  : ch0_last;
  assign xfer      = (state == ST_DATA) && sel_valid;
  assign cnt_hit   = (byte_cnt == BYTE_LAST);
  assign end_frame = xfer && (sel_last || cnt_hit);

  rr_arbiter2 u_arb (
    .req        ({ch1_valid, ch0_valid}),
    .last_grant (last_grant),
    .arb_en     ((state == ST_IDLE) && link_en),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // Scheduler FSM; encoder outputs register the symbol belonging to the state being left
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_OFF;
      align_cnt  <= '0;
      byte_cnt   <= '0;
      last_grant <= 1'b1;
      trunc_pend <= 1'b0;
      grant      <= 1'b0;
      trunc      <= 1'b0;
      aligned    <= 1'b0;
      enc_data   <= 8'h00;
      enc_k      <= 1'b0;
      enc_enb    <= 1'b0;
    end else begin
      trunc   <= 1'b0;
      // aligned tracks the symbol stream: it rises with the first idle comma, drops with enb
      aligned <= (state == ST_IDLE) || (state == ST_SOF) ||
                 (state == ST_DATA) || (state == ST_EOF);
      case (state)
        ST_OFF: begin
          enc_enb   <= 1'b0;
          enc_data  <= 8'h00;
          enc_k     <= 1'b0;
          align_cnt <= '0;
          if (link_en) state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          enc_enb  <= 1'b1;
          enc_data <= K28_5;
          enc_k    <= 1'b1;
          if (!link_en) begin
            state <= ST_OFF;
          end else if (align_cnt == ALIGN_LAST) begin
            state <= ST_IDLE;
          end else begin
            align_cnt <= align_cnt + AW'(1);
          end
        end
        ST_IDLE: begin
          enc_enb  <= 1'b1;
          enc_data <= K28_5;
          enc_k    <= 1'b1;
          if (!link_en) begin
            state <= ST_OFF;
          end else if (gnt_valid) begin
            grant      <= gnt;
            last_grant <= gnt;
            state      <= ST_SOF;
          end
        end
        ST_SOF: begin
          enc_enb  <= 1'b1;
          enc_data <= K27_7;
          enc_k    <= 1'b1;
          state    <= ST_DATA;
        end
        ST_DATA: begin
          enc_enb <= 1'b1;
          if (xfer) begin
            enc_data <= sel_data;
            enc_k    <= 1'b0;
            byte_cnt <= byte_cnt + BW'(1);
            if (end_frame) begin
              // a cut frame is flagged alongside its FD symbol two cycles on
              trunc_pend <= !sel_last;
              state      <= ST_EOF;
            end
          end else begin
            enc_data <= K28_0;
            enc_k    <= 1'b1;
          end
        end
        ST_EOF: begin
          enc_enb    <= 1'b1;
          enc_data   <= K29_7;
          enc_k      <= 1'b1;
          byte_cnt   <= '0;
          trunc      <= trunc_pend;
          trunc_pend <= 1'b0;
          state      <= link_en ? ST_IDLE : ST_OFF;
        end
        default: begin
          enc_enb  <= 1'b0;
          enc_data <= 8'h00;
          enc_k    <= 1'b0;
          state    <= ST_OFF;
        end
      endcase
    end
  end

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
Transmit-side controller that sequences the 8b/10b encoder (`encoder` / `encoderSynth`), driving its `entradas`, `K` and `enb` inputs one symbol per clock. After link enable it sends an alignment run of K28.5 commas. It then shares the encoder between two byte-stream requesters, framing each packet as SOF (K27.7), data and EOF (K29.7). Arbitration is round-robin at frame boundaries, and K28.5 idle commas fill the line between frames.

Parameters:
ALIGN_COUNT, 4, number of K28.5 commas sent in ALIGN before the link is declared aligned (>=1)
MAX_LEN, 16, maximum data bytes per frame; the byte that reaches MAX_LEN is forced to be the last one (>=1)

Ports:
clk  input  1  symbol clock
rst  input  1  asynchronous, active-low reset
link_en  input  1  link enable; sampled at every posedge
ch0_valid  input  1  channel 0 has a byte available
ch0_data  input  8  channel 0 byte
ch0_last  input  1  channel 0 byte is the last of its frame
ch0_ready  output  1  channel 0 byte accepted this cycle (valid & ready at posedge = transfer)
ch1_valid, ch1_data[7:0], ch1_last, ch1_ready  same as channel 0, for channel 1
enc_data  output  8  byte to encoder `entradas`, registered
enc_k  output  1  control-symbol flag to encoder `K`, registered
enc_enb  output  1  encoder enable, registered
aligned  output  1  high once ALIGN has completed and until the link returns to OFF
grant  output  1  channel currently owning the frame (valid in SOF/DATA/EOF)
trunc  output  1  one-cycle pulse when a frame is cut at MAX_LEN

Behaviour:
- Reset (rst=0, asynchronous):
  - state OFF; enc_data=8'h00, enc_k=0, enc_enb=0.
  - aligned=0, grant=0, trunc=0, last_grant=1 (so channel 0 wins the first tie).
  - counters cleared; ch*_ready=0.
  - Applies immediately, even mid-frame; the partial frame is dropped with no EOF.
- All enc_* outputs are registered: the symbol chosen by the state entered at posedge n is visible after posedge n and held for one cycle.
- ch*_ready is combinational from registered state only: it equals (state==DATA && grant==ch), with no dependence on valid.
- OFF:
  - Outputs enc_enb=0, enc_data=0, enc_k=0.
  - If link_en=1, go to ALIGN.
- ALIGN:
  - Outputs enc_enb=1, 8'hBC, k=1 for exactly ALIGN_COUNT cycles, then goes to IDLE and sets aligned=1.
  - If link_en=0 at any point, go to OFF.
- IDLE:
  - Outputs 8'hBC, k=1.
  - If link_en=0, go to OFF (aligned cleared).
  - Otherwise, if any chX_valid, arbitrate:
    - only one valid: grant that channel;
    - both valid: grant !last_grant.
  - Then go to SOF and update last_grant.
- SOF:
  - Outputs 8'hFB, k=1.
  - Always followed by DATA; no byte is accepted during SOF.
- DATA:
  - On each valid&ready transfer, outputs the granted byte with k=0 and increments the byte count.
  - If valid=0, outputs filler 8'h1C (K28.0), k=1, and the frame continues.
  - Exit to EOF after a transfer with last=1, or after the transfer that makes the count equal MAX_LEN.
  - In the MAX_LEN case with last=0, pulse trunc in the same cycle as the EOF symbol.
  - Any remaining bytes of that source frame begin a new frame only after re-arbitration.
- EOF:
  - Outputs 8'hFD, k=1; the byte count clears.
  - Next state is IDLE, or OFF if link_en=0.
- link_en=0 during SOF/DATA:
  - The frame completes normally (through EOF) before OFF; DATA does not terminate early.
  - The next IDLE→OFF decision sees link_en.
- Simultaneous events:
  - EOF with link_en=0 goes directly to OFF.
  - Both channels valid in IDLE resolve by round-robin only; there is no fixed priority.
- Frame-level latency: SOF appears 1 cycle after the IDLE cycle in which valid is seen; the first data byte can be accepted at the posedge ending the SOF cycle (state DATA on the next cycle).

Decomposition:
- Package link_pkg:
  - symbol constants K28_5=8'hBC, K27_7=8'hFB, K29_7=8'hFD, K28_0=8'h1C;
  - state enumeration OFF/ALIGN/IDLE/SOF/DATA/EOF as 3-bit localparams.
- One sub-module: rr_arbiter2.
  - Inputs: req[1:0], last_grant, arb_en.
  - Outputs: gnt_valid, gnt (combinational).
  - Instantiated once.
- Counters (align and byte) stay in the top module.

Test Plan:
- Reset: rst=0 then released with link_en=0 → enc_enb=0, enc_data=00, enc_k=0, aligned=0 indefinitely; asserting rst mid-DATA returns all outputs to these values within the same time step.
- Alignment: link_en=1 with ALIGN_COUNT=4 → exactly 4 cycles of BC/k=1, then aligned=1 and continuous BC idle.
- Single frame: ch0 sends bytes 8'h03, 8'h00, 8'h11 (last on 11) → encoder sees FB(k1), 03, 00, 11 (k0), FD(k1), BC; ch0_ready high for 3 cycles.
- Round-robin: both channels valid with 2-byte frames → frames alternate ch0, ch1, ch0; grant toggles; no idle BC between EOF and the next SOF beyond one IDLE cycle.
- Gap and truncation: ch1 drops valid for 2 cycles mid-frame → two 1C/k1 fillers; with MAX_LEN=4 and a 6-byte frame → 4 bytes, FD, trunc pulse, then a new SOF for the remaining 2 bytes.
- Disable mid-frame: link_en=0 during DATA → frame finishes with FD, then enc_enb=0 and aligned=0 in OFF.
